// File: rtl/cordic_sequencer.sv
// cordic_sequencer
// Round-robin front end and iteration sequencer for the shared iterative cordic
// datapath. One operation is in flight at a time: accept, load, ITER enabled
// micro-rotations with ADDR stepping 0..ITER-1, then a held tagged completion.
module cordic_sequencer #(
  parameter int NREQ = 2,
  parameter int ITER = 16,
  parameter int AW   = 5,
  parameter int DW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_angle,
  output logic [NREQ-1:0]   req_ready,
  output logic              cdc_load,
  output logic [DW-1:0]     cdc_angle,
  output logic              cdc_en,
  output logic [AW-1:0]     ADDR,
  output logic              rsp_valid,
  output logic [1:0]        rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0]    NREQ_W    = 3'(NREQ);
  localparam logic [1:0]    LAST_IDX  = 2'(NREQ - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ITER - 1);

  state_t          state_q;
  logic [1:0]      rr_ptr_q;
  logic [1:0]      rr_ptr_d;
  logic            cdc_load_q;
  logic [DW-1:0]   cdc_angle_q;
  logic            cdc_en_q;
  logic [AW-1:0]   addr_q;
  logic            rsp_valid_q;
  logic [1:0]      rsp_id_q;
  logic            busy_q;

  logic [3:0]      valid_ext_s;
  logic [2:0]      idx_s;
  logic [1:0]      grant_s;
  logic            found_s;
  logic [NREQ-1:0] req_ready_s;
  logic            accept_s;

  // Round-robin search: first pending requester at or after rr_ptr, wrapping mod NREQ.
  always_comb begin
    valid_ext_s = 4'(req_valid);
    idx_s       = 3'd0;
    grant_s     = 2'd0;
    found_s     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, rr_ptr_q} + 3'(k);
      if (idx_s >= NREQ_W) begin
        idx_s = idx_s - NREQ_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && valid_ext_s[idx_s[1:0]]) begin
        found_s = 1'b1;
        grant_s = idx_s[1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot accept, offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready_s[i] = rst_n && (state_q == ST_IDLE) && found_s && (grant_s == 2'(i));
    end
    accept_s = |req_ready_s;
    if (grant_s == LAST_IDX) begin
      rr_ptr_d = 2'd0;
    end else begin
      rr_ptr_d = grant_s + 2'd1;
    end
  end

  // Sequencer FSM with all datapath-facing outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 2'd0;
      cdc_load_q  <= 1'b0;
      cdc_angle_q <= '0;
      cdc_en_q    <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q     <= ST_LOAD;
            cdc_load_q  <= 1'b1;
            cdc_angle_q <= req_angle[grant_s*DW +: DW];
            rsp_id_q    <= grant_s;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q    <= ST_RUN;
          cdc_load_q <= 1'b0;
          cdc_en_q   <= 1'b1;
          addr_q     <= '0;
        end
        ST_RUN: begin
          if (addr_q == LAST_ADDR) begin
            state_q     <= ST_DONE;
            cdc_en_q    <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b1;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cdc_load_q  <= 1'b0;
          cdc_en_q    <= 1'b0;
          addr_q      <= '0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign cdc_load  = cdc_load_q;
  assign cdc_angle = cdc_angle_q;
  assign cdc_en    = cdc_en_q;
  assign ADDR      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench for cordic_sequencer: ITER=16 instance for the main scenarios,
// plus an ITER=4 instance for the short-sequence case.
module tb_cordic_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cnt = 0;

  // ITER=16 instance
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req_angle = 32'h0;
  logic [1:0]  req_ready;
  logic        cdc_load, cdc_en, rsp_valid, busy;
  logic [15:0] cdc_angle;
  logic [4:0]  addr;
  logic [1:0]  rsp_id;
  logic        rsp_ready = 1'b0;

  // ITER=4 instance
  logic [1:0]  v4_req_valid = 2'b00;
  logic [31:0] v4_req_angle = 32'h0;
  logic [1:0]  v4_req_ready;
  logic        v4_cdc_load, v4_cdc_en, v4_rsp_valid, v4_busy;
  logic [15:0] v4_cdc_angle;
  logic [4:0]  v4_addr;
  logic [1:0]  v4_rsp_id;
  logic        v4_rsp_ready = 1'b0;

  cordic_sequencer #(.NREQ(2), .ITER(16), .AW(5), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .cdc_load(cdc_load), .cdc_angle(cdc_angle),
    .cdc_en(cdc_en), .ADDR(addr), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  cordic_sequencer #(.NREQ(2), .ITER(4), .AW(5), .DW(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4_req_valid), .req_angle(v4_req_angle),
    .req_ready(v4_req_ready), .cdc_load(v4_cdc_load), .cdc_angle(v4_cdc_angle),
    .cdc_en(v4_cdc_en), .ADDR(v4_addr), .rsp_valid(v4_rsp_valid), .rsp_id(v4_rsp_id),
    .rsp_ready(v4_rsp_ready), .busy(v4_busy)
  );

  always #5 clk = ~clk;

  // free-running cycle count and accept counter for the ITER=16 instance
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ((req_valid & req_ready) != 2'b00)) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op on the ITER=16 instance and walks it to DONE (rsp_ready left as is).
  task automatic do_op(input logic [1:0] vmask, input logic [1:0] gidx,
                       input logic [15:0] exp_angle, input bit pulse);
    logic [1:0] exp_rdy;
    exp_rdy = 2'b01 << gidx;
    req_valid = vmask;
    #1;
    check("grant", 32'(req_ready), 32'(exp_rdy));
    tick();
    req_valid = 2'b00;
    #1;
    check("load", 32'(cdc_load), 32'd1);
    check("angle", 32'(cdc_angle), 32'(exp_angle));
    check("busy_load", 32'(busy), 32'd1);
    check("en_load", 32'(cdc_en), 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("run_en", 32'(cdc_en), 32'd1);
      check("run_addr", 32'(addr), 32'(k));
      if (pulse && k == 5) begin
        req_valid = 2'b10;
        #1;
        check("busy_ignore", 32'(req_ready), 32'd0);
      end else if (pulse && k == 7) begin
        req_valid = 2'b00;
      end
    end
    tick();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(gidx));
    check("done_en", 32'(cdc_en), 32'd0);
    check("done_addr", 32'(addr), 32'd0);
  endtask

  initial begin
    int last_acc;
    int acc_before;
    logic [1:0] exp_g;
    req_angle = {16'hBEEF, 16'h1234};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {req_ready, cdc_load, cdc_en, addr, rsp_valid, rsp_id, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: single op from requester 0
    do_op(2'b01, 2'd0, 16'h1234, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t1_release", 32'(rsp_valid), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 3: backpressure on requester 1 op
    do_op(2'b10, 2'd1, 16'hBEEF, 1'b0);
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_en", 32'(cdc_en), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_no_accept", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("bp_release", 32'(rsp_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);

    // 2: fairness with both requesters held
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    last_acc = 0;
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 40 && req_ready == 2'b00; c++) tick();
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_grant", 32'(req_ready), 32'(exp_g));
      if (n > 0) check("rr_spacing", 32'(cyc - last_acc), 32'd19);
      last_acc = cyc;
      tick();
    end
    req_valid = 2'b00;
    for (int c = 0; c < 40 && busy != 1'b0; c++) tick();
    check("rr_drain", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // 5: requests during RUN are ignored
    acc_before = acc_cnt;
    do_op(2'b01, 2'd0, 16'h1234, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (3) tick();
    check("op_count", 32'(acc_cnt - acc_before), 32'd1);
    check("ignore_idle", 32'(busy), 32'd0);

    // 4: reset mid-RUN at ADDR=7
    req_valid = 2'b11;
    #1;
    check("pre_rst_grant", 32'(req_ready), 32'b10);
    tick();
    tick();
    for (int c = 0; c < 7; c++) tick();
    check("pre_rst_addr", 32'(addr), 32'd7);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {req_ready, cdc_load, cdc_en, addr, rsp_valid, rsp_id, busy}, 32'd0);
    check("rst_mid_angle", 32'(cdc_angle), 32'd0);
    tick();
    tick();
    #4;
    rst_n = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b01);
    check("post_rst_rsp", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 2'b00;
    check("post_rst_load", 32'(cdc_load), 32'd1);
    check("post_rst_id_src", 32'(cdc_angle), 32'h1234);
    for (int c = 0; c < 17; c++) tick();
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("post_rst_rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // 6: ITER=4 instance
    v4_req_angle = {16'h0000, 16'h0ACE};
    v4_req_valid = 2'b01;
    #1;
    check("i4_grant", 32'(v4_req_ready), 32'b01);
    tick();
    v4_req_valid = 2'b00;
    check("i4_load", 32'(v4_cdc_load), 32'd1);
    check("i4_angle", 32'(v4_cdc_angle), 32'h0ACE);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("i4_en", 32'(v4_cdc_en), 32'd1);
      check("i4_addr", 32'(v4_addr), 32'(k));
      check("i4_no_rsp", 32'(v4_rsp_valid), 32'd0);
    end
    tick();
    check("i4_rsp", 32'(v4_rsp_valid), 32'd1);
    check("i4_en_off", 32'(v4_cdc_en), 32'd0);
    v4_rsp_ready = 1'b1;
    tick();
    v4_rsp_ready = 1'b0;
    check("i4_release", 32'(v4_rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
